// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port 256x16 data RAM between the CPU MA
// stage and the debug/loader port. The CPU normally wins. A debug request
// that has lost STARVE_LIMIT consecutive cycles wins the next contended
// cycle. HALT mode hands the RAM exclusively to the debug port.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // CPU MA-stage port
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    // debug/loader port
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [7:0]  dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [15:0] dbg_rdata,
    input  logic        dbg_halt,
    output logic        halted,
    // RAM side
    output logic        ram_rd,
    output logic        ram_wr,
    output logic [7:0]  ram_raddr,
    output logic [7:0]  ram_waddr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_HALT   = 1'b1;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [0:0] r_state;
    logic [7:0] r_starve_cnt;
    logic       r_rd_pend;
    logic       r_rd_owner_dbg;

    logic       w_cpu_gnt;
    logic       w_dbg_gnt;
    logic       w_starved;
    logic       w_sel_we;
    logic [7:0] w_sel_addr;
    logic [15:0] w_sel_wdata;

    assign w_starved = (r_starve_cnt == LIMIT) && dbg_req;

    // Grant selection; all grants forced low while reset is held.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (rst) begin
            if (r_state == S_HALT) begin
                w_dbg_gnt = dbg_req;
            end else if (w_starved) begin
                w_dbg_gnt = 1'b1;
            end else begin
                w_cpu_gnt = cpu_req;
                w_dbg_gnt = dbg_req & ~cpu_req;
            end
        end
    end

    // Route the granted requester's fields onto the RAM; zeros when idle.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = 8'h00;
        w_sel_wdata = 16'h0000;
        ram_rd      = 1'b0;
        ram_wr      = 1'b0;
        ram_raddr   = 8'h00;
        ram_waddr   = 8'h00;
        ram_wdata   = 16'h0000;
        if (w_cpu_gnt) begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
        end else if (w_dbg_gnt) begin
            w_sel_we    = dbg_we;
            w_sel_addr  = dbg_addr;
            w_sel_wdata = dbg_wdata;
        end
        if (w_cpu_gnt || w_dbg_gnt) begin
            ram_rd = ~w_sel_we;
            ram_wr = w_sel_we;
            if (w_sel_we) begin
                ram_waddr = w_sel_addr;
                ram_wdata = w_sel_wdata;
            end else begin
                ram_raddr = w_sel_addr;
            end
        end
    end

    // Mode FSM: dbg_halt is sampled at each edge, so changes apply next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_NORMAL;
        end else begin
            r_state <= dbg_halt ? S_HALT : S_NORMAL;
        end
    end

    // Count consecutive lost debug cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= 8'h00;
        end else if ((r_state == S_HALT) || !dbg_req || w_dbg_gnt) begin
            r_starve_cnt <= 8'h00;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'h01;
        end
    end

    // Remember a granted read and who issued it, for next-cycle rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_pend      <= 1'b0;
            r_rd_owner_dbg <= 1'b0;
        end else begin
            r_rd_pend      <= (w_cpu_gnt & ~cpu_we) | (w_dbg_gnt & ~dbg_we);
            r_rd_owner_dbg <= w_dbg_gnt;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign cpu_stall  = rst & cpu_req & ~w_cpu_gnt;
    assign halted     = (r_state == S_HALT);
    assign cpu_rvalid = r_rd_pend & ~r_rd_owner_dbg;
    assign dbg_rvalid = r_rd_pend &  r_rd_owner_dbg;
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x16 RAM attached.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [15:0] dbg_rdata;
    logic        dbg_halt, halted;
    logic        ram_rd, ram_wr;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [15:0] ram_wdata, ram_rdata;

    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_halt(dbg_halt), .halted(halted),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural RAM: write at the edge, read data registered one cycle later.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;
    endtask

    task automatic check_ram_idle(input string tag);
        check({tag, "_rd"}, 32'(ram_rd), 32'd0);
        check({tag, "_wr"}, 32'(ram_wr), 32'd0);
        check({tag, "_raddr"}, 32'(ram_raddr), 32'd0);
        check({tag, "_waddr"}, 32'(ram_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        ram_rdata = 16'h0000;
        idle_inputs();
        dbg_halt = 1'b0;
        rst = 1'b0;
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        #2;
        // Reset: requests present but nothing may be granted
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check_ram_idle("rst_ram");
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;

        // Idle
        tick();
        #1;
        check_ram_idle("idle_ram");
        tick();
        check("idle_starve", 32'(dut.r_starve_cnt), 32'd0);

        // CPU write 0xBEEF @0x10, then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        #1;
        check("wr_gnt", 32'(cpu_gnt), 32'd1);
        check("wr_ram_wr", 32'(ram_wr), 32'd1);
        check("wr_waddr", 32'(ram_waddr), 32'h10);
        check("wr_wdata", 32'(ram_wdata), 32'hBEEF);
        check("wr_raddr", 32'(ram_raddr), 32'd0);
        tick();
        cpu_we = 1'b0; cpu_wdata = 16'h0000;
        #1;
        check("rd_gnt", 32'(cpu_gnt), 32'd1);
        check("rd_ram_rd", 32'(ram_rd), 32'd1);
        check("rd_raddr", 32'(ram_raddr), 32'h10);
        check("rd_waddr", 32'(ram_waddr), 32'd0);
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        check("rd_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        tick();
        check("rd_rvalid_drop", 32'(cpu_rvalid), 32'd0);

        // Contention: debug wins every 5th cycle with limit 4
        cpu_req = 1'b1; cpu_addr = 8'h20;
        dbg_req = 1'b1; dbg_addr = 8'h30;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("cont%0d_cpu_gnt", i), 32'(cpu_gnt), 32'((i % 5) != 4));
            check($sformatf("cont%0d_dbg_gnt", i), 32'(dbg_gnt), 32'((i % 5) == 4));
            check($sformatf("cont%0d_stall", i), 32'(cpu_stall), 32'((i % 5) == 4));
            if (i > 0) begin
                check($sformatf("cont%0d_dbg_rvalid", i), 32'(dbg_rvalid), 32'(((i - 1) % 5) == 4));
                check($sformatf("cont%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(((i - 1) % 5) != 4));
            end
            tick();
        end
        idle_inputs();
        tick();

        // Halt entry: assert cycle still follows NORMAL rules
        cpu_req = 1'b1; cpu_addr = 8'h02;
        dbg_halt = 1'b1;
        #1;
        check("halt_assert_halted", 32'(halted), 32'd0);
        check("halt_assert_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'(i); dbg_wdata = 16'(i + 1);
            #1;
            check($sformatf("halt%0d_halted", i), 32'(halted), 32'd1);
            check($sformatf("halt%0d_stall", i), 32'(cpu_stall), 32'd1);
            check($sformatf("halt%0d_cpu_gnt", i), 32'(cpu_gnt), 32'd0);
            check($sformatf("halt%0d_dbg_gnt", i), 32'(dbg_gnt), 32'd1);
            check($sformatf("halt%0d_waddr", i), 32'(ram_waddr), 32'(i));
            tick();
        end
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;
        dbg_halt = 1'b0;
        #1;
        check("halt_deassert_halted", 32'(halted), 32'd1);
        check("halt_deassert_stall", 32'(cpu_stall), 32'd1);
        tick();
        #1;
        check("post_halt_halted", 32'(halted), 32'd0);
        check("post_halt_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("post_halt_raddr", 32'(ram_raddr), 32'h02);
        tick();
        idle_inputs();
        #1;
        check("post_halt_rvalid", 32'(cpu_rvalid), 32'd1);
        check("post_halt_rdata", 32'(cpu_rdata), 32'h0003);
        tick();

        // Pending CPU read across halt entry
        cpu_req = 1'b1; cpu_addr = 8'h05;
        dbg_halt = 1'b1;
        #1;
        check("pend_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_req = 1'b0; cpu_addr = 8'h00;
        #1;
        check("pend_rvalid", 32'(cpu_rvalid), 32'd1);
        check("pend_halted", 32'(halted), 32'd1);
        dbg_halt = 1'b0;
        tick();
        tick();

        // Reset asserted while a debug read is pending
        dbg_req = 1'b1; dbg_addr = 8'h01;
        #1;
        check("rstmid_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("rstmid_raddr", 32'(ram_raddr), 32'h01);
        rst = 1'b0;
        cpu_req = 1'b1;
        #1;
        check("rstmid_dbg_gnt_low", 32'(dbg_gnt), 32'd0);
        check("rstmid_cpu_gnt_low", 32'(cpu_gnt), 32'd0);
        check("rstmid_stall_low", 32'(cpu_stall), 32'd0);
        check_ram_idle("rstmid_ram");
        tick();
        check("rstmid_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rstmid_halted", 32'(halted), 32'd0);
        idle_inputs();
        rst = 1'b1;
        #1;
        check_ram_idle("rstrel_ram");
        tick();
        check("rstrel_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rstrel_starve", 32'(dut.r_starve_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
